// File: rtl/sec_min_countdown.sv
// mm:ss BCD countdown timer with load/start/pause control and a one-second tick divider.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN (reload the preset instead of stopping at 00:00).
module sec_min_countdown #(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] secUnits_in,
    input  logic [2:0] secTens_in,
    input  logic [3:0] minUnits_in,
    input  logic [2:0] minTens_in,
    output logic [3:0] secUnits,
    output logic [2:0] secTens,
    output logic [3:0] minUnits,
    output logic [2:0] minTens,
    output logic       running,
    output logic       done,
    output logic       done_pulse
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [13:0]   r_val, w_val;
    logic [13:0]   r_rld, w_rld;
    logic          r_pulse, w_pulse;
    logic [13:0]   w_preset;

    function automatic logic [3:0] clamp_units(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [2:0] clamp_tens(input logic [2:0] d);
        return (d > 3'd5) ? 3'd5 : d;
    endfunction

    // Value is packed {minTens, minUnits, secTens, secUnits}; 00:00 saturates.
    function automatic logic [13:0] bcd_dec(input logic [13:0] v);
        logic [2:0] mt;
        logic [3:0] mu;
        logic [2:0] st;
        logic [3:0] su;
        {mt, mu, st, su} = v;
        if (v == 14'd0) begin
            return v;
        end else if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (st != 3'd0) begin
                st = st - 3'd1;
            end else begin
                st = 3'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    mt = mt - 3'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    assign w_preset = {clamp_tens(minTens_in), clamp_units(minUnits_in),
                       clamp_tens(secTens_in), clamp_units(secUnits_in)};

    // Next-state, tick divider and digit update; load overrides every state.
    always_comb begin
        w_state = r_state;
        w_val   = r_val;
        w_rld   = r_rld;
        w_cnt   = r_cnt;
        w_pulse = 1'b0;
        if (load) begin
            w_val   = w_preset;
            w_rld   = w_preset;
            w_cnt   = '0;
            w_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_PAUSE: begin
                    if (start) begin
                        if (r_val == 14'd0) begin
                            w_state = S_DONE;
                        end else begin
                            w_state = S_RUN;
                        end
                    end else begin
                        w_state = r_state;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        w_state = S_PAUSE;
                    end else if (r_cnt != TICK_LAST) begin
                        w_cnt = r_cnt + CW'(1);
                    end else begin
                        w_cnt = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (r_val == 14'd0) begin
                            w_val = r_rld;
                        end else begin
                            w_val   = bcd_dec(r_val);
                            w_pulse = (w_val == 14'd0);
                        end
`else
                        w_val = bcd_dec(r_val);
                        if (w_val == 14'd0) begin
                            w_pulse = 1'b1;
                            w_state = S_DONE;
                        end else begin
                            w_state = S_RUN;
                        end
`endif
                    end
                end
                S_DONE:  w_state = S_DONE;
                default: w_state = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_val   <= 14'd0;
            r_rld   <= 14'd0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state;
            r_val   <= w_val;
            r_rld   <= w_rld;
            r_cnt   <= w_cnt;
            r_pulse <= w_pulse;
        end
    end

    assign {minTens, minUnits, secTens, secUnits} = r_val;
    assign running    = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign done_pulse = r_pulse;

endmodule

// File: doc/sec_min_countdown.md
SEC_MIN_COUNTDOWN -- requirements
Module: sec_min_countdown

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, giving clk cycles per one-second tick (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port load  input  1  load preset digits (level sampled each cycle).
REQ-005 SHALL have port start  input  1  begin or resume countdown.
REQ-006 SHALL have port pause  input  1  suspend countdown.
REQ-007 SHALL have ports secUnits_in[3:0], secTens_in[2:0], minUnits_in[3:0], minTens_in[2:0], all inputs, forming the BCD preset.
REQ-008 SHALL have ports secUnits[3:0], secTens[2:0], minUnits[3:0], minTens[2:0], all registered outputs showing the current BCD value.
REQ-009 SHALL have port running  output  1  high while state is RUN.
REQ-010 SHALL have port done  output  1  high while state is DONE.
REQ-011 SHALL have port done_pulse  output  1  single-cycle strobe when the value reaches 00:00 by counting.

Function
REQ-012 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-013 Priority SHALL be reset > load > start/pause.
REQ-014 load, in any state, SHALL copy preset to the digit outputs and to an internal reload register, clear the tick counter, and go to IDLE next cycle.
REQ-015 Preset digits out of range (units >9, tens >5) SHALL be clamped on load to 9 and 5 respectively.
REQ-016 start in IDLE or PAUSE SHALL go to RUN, or to DONE if the value is 00:00 (no done_pulse in that case); start in RUN or DONE SHALL be ignored.
REQ-017 pause in RUN SHALL go to PAUSE and freeze the tick counter; pause elsewhere SHALL be ignored; with start and pause both high, RUN honours pause and IDLE/PAUSE honour start.
REQ-018 In RUN, the tick counter SHALL count 0..TICK_DIV-1 and wrap; a tick occurs in the cycle the counter equals TICK_DIV-1, so the first decrement lands exactly TICK_DIV cycles after entering RUN from a cleared counter.
REQ-019 Resuming from PAUSE SHALL continue from the frozen tick count, not restart it.
REQ-020 On a tick, the value SHALL decrement by one second: secUnits 0->9 with borrow, secTens 0->5 with borrow, minUnits 0->9 with borrow, minTens decrement; range 59:59..00:00.
REQ-021 A tick taking the value 00:01->00:00 SHALL register 00:00 and assert done_pulse in the same cycle the outputs first read 00:00.
REQ-022 DONE SHALL hold 00:00 and be exited only by load or reset.
REQ-023 running and done SHALL be decoded registered state, with no combinational path from inputs.

Reset
REQ-024 When reset=0 at a clock edge, all digit outputs, the reload register, and the tick counter SHALL be 0, and the state SHALL be IDLE.
REQ-025 After reset, running, done and done_pulse SHALL be 0.
REQ-026 Reset asserted mid-RUN SHALL abandon the countdown with no done_pulse.

Configuration
REQ-027 Macro COUNTDOWN_AUTO_RELOAD_EN SHALL select the behaviour at 00:00.
REQ-028 Without COUNTDOWN_AUTO_RELOAD_EN, reaching 00:00 SHALL go to DONE per REQ-021/022.
REQ-029 With COUNTDOWN_AUTO_RELOAD_EN, reaching 00:00 SHALL assert done_pulse but stay in RUN; the next tick SHALL load the reload register value instead of decrementing; DONE is entered only via REQ-016 (start at 00:00); done_pulse recurs every period.

Verification (TICK_DIV=4)
REQ-030 Load 00:03, start -> digits 00:02, 00:01, 00:00 at 4, 8, 12 cycles after RUN entry; done_pulse exactly one cycle at cycle 12; done stays 1.
REQ-031 Load 10:00, start, run one tick -> 09:59; load 01:00, one tick -> 00:59 (borrow chains).
REQ-032 Load 00:05, start, pause at cycle 6, hold 10 cycles, start -> next decrement 2 cycles after resume (frozen count); running low during PAUSE.
REQ-033 Preset secUnits_in=12, secTens_in=7 with load -> outputs 00:59; start with 00:00 loaded -> done=1, done_pulse=0.
REQ-034 reset=0 mid-RUN at 00:02 -> all outputs 0, IDLE, no done_pulse; load with start in the same cycle -> IDLE with preset and no decrement.
REQ-035 With COUNTDOWN_AUTO_RELOAD_EN, load 00:02, start -> 00:01, 00:00 with done_pulse, then 00:02 on the following tick; running remains 1.
